// File: rtl/ce0_hilo_engine_if.sv
// CE0 pipeline-side bundle: S/E-stage opcode and operands in, stall and M-stage result out.
// Flow control: an E-stage op is consumed on a cycle with !PIPE_HOLD_E && !CE0_STALL_E
// (KILL_E discards it instead); CE0_RESVLD_M_R qualifies CE0_RESULT_M_R for exactly one cycle.
interface ce0_hilo_engine_if;
    logic [11:0] CEI_CE0OP_S_R;
    logic        CEI_INSTM32_S_R_N;
    logic [31:0] CEI_CE0AOP_E_R;
    logic [31:0] CEI_CE0BOP_E_R;
    logic        PIPE_HOLD_E;
    logic        KILL_E;
    logic        CE0_STALL_E;
    logic [31:0] CE0_RESULT_M_R;
    logic        CE0_RESVLD_M_R;
    logic        CE0_BUSY_R;

    modport master (
        output CEI_CE0OP_S_R, CEI_INSTM32_S_R_N, CEI_CE0AOP_E_R, CEI_CE0BOP_E_R,
        output PIPE_HOLD_E, KILL_E,
        input  CE0_STALL_E, CE0_RESULT_M_R, CE0_RESVLD_M_R, CE0_BUSY_R
    );

    modport slave (
        input  CEI_CE0OP_S_R, CEI_INSTM32_S_R_N, CEI_CE0AOP_E_R, CEI_CE0BOP_E_R,
        input  PIPE_HOLD_E, KILL_E,
        output CE0_STALL_E, CE0_RESULT_M_R, CE0_RESVLD_M_R, CE0_BUSY_R
    );
endinterface

// File: rtl/ce0_hilo_engine.sv
// CE0 execution unit: iterative 32x32 multiply / restoring divide with architectural HI/LO,
// plus MTHI/MTLO/MFHI/MFLO moves. dbg_state exposes the FSM state.
module ce0_hilo_engine #(
    parameter int MUL_BITS = 4
) (
    input  logic       CLK,
    input  logic       RESET_N,
    ce0_hilo_engine_if.slave bus,
    output logic [1:0] dbg_state
);
    localparam int MUL_CYC = 32 / MUL_BITS;
    localparam int PW      = 32 + MUL_BITS;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
    typedef enum logic [3:0] {
        OP_NOP = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV = 4'd3, OP_DIVU = 4'd4,
        OP_MTHI = 4'd5, OP_MTLO = 4'd6, OP_MFHI = 4'd7, OP_MFLO = 4'd8
    } op_t;

    state_t      state;
    op_t         op_e;
    op_t         op_s;
    logic [4:0]  cnt;
    logic [31:0] hi, lo, b_reg, result;
    logic [63:0] p;
    logic        is_div, neg_q, neg_r, div0, busy, resvld;

    logic [3:0]  func;
    logic        unused_op_bits;
    logic        stall, advance, issue;
    logic [31:0] a, b, a_mag, b_mag;
    logic        signed_op, a_neg, b_neg;
    logic [PW-1:0] partial, mul_sum;
    logic [63:0] mul_next, div_next, prod_fix;
    logic [32:0] trial;
    logic [33:0] diff;
    logic [31:0] rem_next, q_fix, r_fix;

    assign func           = bus.CEI_CE0OP_S_R[3:0];
    assign unused_op_bits = ^bus.CEI_CE0OP_S_R[11:4];

    always_comb begin
        op_s = OP_NOP;
        if (!bus.CEI_INSTM32_S_R_N && func != 4'd0 && func <= 4'd8)
            op_s = op_t'(func);
    end

    // Any CE0 op in E waits for the engine to drain, so HI/LO is never read or written mid-op.
    assign stall   = (op_e != OP_NOP) && (state != S_IDLE);
    assign advance = !bus.PIPE_HOLD_E && !stall;
    assign issue   = advance && !bus.KILL_E && (op_e != OP_NOP);

    assign a         = bus.CEI_CE0AOP_E_R;
    assign b         = bus.CEI_CE0BOP_E_R;
    assign signed_op = (op_e == OP_MULT) || (op_e == OP_DIV);
    assign a_neg     = signed_op && a[31];
    assign b_neg     = signed_op && b[31];
    assign a_mag     = a_neg ? (32'd0 - a) : a;
    assign b_mag     = b_neg ? (32'd0 - b) : b;

    // Shift-add: p[63:32] accumulates, p[31:0] holds the remaining multiplier digits.
    assign partial  = {{MUL_BITS{1'b0}}, b_reg} * {{32{1'b0}}, p[MUL_BITS-1:0]};
    assign mul_sum  = {{MUL_BITS{1'b0}}, p[63:32]} + partial;
    assign mul_next = {mul_sum, p[31:MUL_BITS]};

    // Restoring divide: p[63:32] is the partial remainder, p[31:0] shifts dividend out / quotient in.
    assign trial    = {p[63:32], p[31]};
    assign diff     = {1'b0, trial} - {2'b00, b_reg};
    assign rem_next = diff[33] ? trial[31:0] : diff[31:0];
    assign div_next = {rem_next, p[30:0], ~diff[33]};

    assign prod_fix = neg_q ? (64'd0 - p) : p;
    assign q_fix    = neg_q ? (32'd0 - p[31:0]) : p[31:0];
    assign r_fix    = neg_r ? (32'd0 - p[63:32]) : p[63:32];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= S_IDLE;
            op_e   <= OP_NOP;
            cnt    <= 5'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            b_reg  <= 32'd0;
            p      <= 64'd0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            busy   <= 1'b0;
            result <= 32'd0;
            resvld <= 1'b0;
        end else begin
            resvld <= 1'b0;
            if (advance)
                op_e <= op_s;
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        case (op_e)
                            OP_MULT, OP_MULTU: begin
                                p      <= {32'd0, a_mag};
                                b_reg  <= b_mag;
                                neg_q  <= a_neg ^ b_neg;
                                is_div <= 1'b0;
                                cnt    <= 5'(MUL_CYC - 1);
                                busy   <= 1'b1;
                                state  <= S_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                p      <= {32'd0, a_mag};
                                b_reg  <= b_mag;
                                neg_q  <= a_neg ^ b_neg;
                                neg_r  <= a_neg;
                                div0   <= (b == 32'd0);
                                is_div <= 1'b1;
                                cnt    <= 5'd31;
                                busy   <= 1'b1;
                                state  <= S_DIV;
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            OP_MFHI: begin
                                result <= hi;
                                resvld <= 1'b1;
                            end
                            OP_MFLO: begin
                                result <= lo;
                                resvld <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    p   <= mul_next;
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd0)
                        state <= S_FIX;
                end
                S_DIV: begin
                    p   <= div_next;
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd0)
                        state <= S_FIX;
                end
                S_FIX: begin
                    // Divide by zero still runs the full loop; only LO is overridden.
                    if (is_div) begin
                        lo <= div0 ? 32'hFFFF_FFFF : q_fix;
                        hi <= r_fix;
                    end else begin
                        hi <= prod_fix[63:32];
                        lo <= prod_fix[31:0];
                    end
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.CE0_STALL_E    = stall;
    assign bus.CE0_RESULT_M_R = result;
    assign bus.CE0_RESVLD_M_R = resvld;
    assign bus.CE0_BUSY_R     = busy;
    assign dbg_state          = state;
endmodule
